// File: rtl/xadc_drp_sched.sv
// xadc_drp_sched: arbitrates the single XADC DRP port between one-shot host
// transactions and a periodic poller that caches a list of DRP reads.
module xadc_drp_sched #(
   parameter int unsigned pNUM_CH      = 6,
   parameter int unsigned pPOLL_PERIOD = 1024,
   parameter int unsigned pTIMEOUT     = 64
) (
   input  logic                    clk_usb,
   input  logic                    reset_i,
   input  logic                    host_req,
   input  logic                    host_we,
   input  logic [6:0]              host_addr,
   input  logic [15:0]             host_din,
   output logic                    host_busy,
   output logic                    host_ack,
   output logic [15:0]             host_dout,
   output logic                    host_timeout,
   input  logic                    poll_en,
   input  logic [pNUM_CH*7-1:0]    poll_addr,
   output logic [pNUM_CH*16-1:0]   result,
   output logic [pNUM_CH-1:0]      result_valid,
   output logic [7:0]              timeout_cnt,
   output logic [6:0]              drp_addr,
   output logic                    drp_den,
   output logic                    drp_dwe,
   output logic [15:0]             drp_din,
   input  logic [15:0]             drp_dout,
   input  logic                    drp_drdy
);

   localparam int unsigned SW = (pNUM_CH > 1) ? $clog2(pNUM_CH) : 1;
   localparam int unsigned TW = $clog2(pPOLL_PERIOD);
   localparam int unsigned CW = $clog2(pTIMEOUT);
   localparam logic [TW-1:0] TMR_RELOAD = TW'(pPOLL_PERIOD - 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(pTIMEOUT - 1);
   localparam logic [SW-1:0] SLOT_LAST  = SW'(pNUM_CH - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
   state_t state, state_nxt;

   logic                     host_pending, poll_pending;
   logic                     cur_host, last_host, grant_host;
   logic                     h_we;
   logic [6:0]               h_addr;
   logic [15:0]              h_din;
   logic [SW-1:0]            slot;
   logic [TW-1:0]            poll_tmr;
   logic [CW-1:0]            wait_cnt;
   logic [pNUM_CH-1:0][15:0] res_q;
   logic [6:0]               poll_sel;
   logic                     host_accept, drdy_hit, timed_out;

   assign host_busy   = host_pending | (cur_host & ((state == ISSUE) | (state == WAIT)));
   assign host_accept = host_req & ~host_busy;
   assign drdy_hit    = (state == WAIT) & drp_drdy;
   assign timed_out   = (state == WAIT) & ~drp_drdy & (wait_cnt == CNT_LAST);
   // on a tie the requester that was not served last wins; last_host resets to 0 so host wins first
   assign grant_host  = host_pending & (~poll_pending | ~last_host);
   assign poll_sel    = poll_addr[7*int'(slot) +: 7];

   assign drp_den   = (state == ISSUE);
   assign drp_dwe   = (state == ISSUE) & cur_host & h_we;
   assign drp_addr  = (state != ISSUE) ? '0 : (cur_host ? h_addr : poll_sel);
   assign drp_din   = ((state == ISSUE) & cur_host) ? h_din : '0;
   assign host_ack  = (state == DONE) & cur_host;
   assign result    = res_q;

   always_ff @(posedge clk_usb) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (host_pending | poll_pending) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (drdy_hit | timed_out) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         host_pending <= 1'b0;
         poll_pending <= 1'b0;
         cur_host     <= 1'b0;
         last_host    <= 1'b0;
         h_we         <= 1'b0;
         h_addr       <= '0;
         h_din        <= '0;
         slot         <= '0;
         poll_tmr     <= TMR_RELOAD;
         wait_cnt     <= '0;
         res_q        <= '0;
         result_valid <= '0;
         host_dout    <= '0;
         host_timeout <= 1'b0;
         timeout_cnt  <= '0;
      end else begin
         if (host_accept) begin
            host_pending <= 1'b1;
            h_we         <= host_we;
            h_addr       <= host_addr;
            h_din        <= host_din;
            host_timeout <= 1'b0;
         end else if ((state == ISSUE) && cur_host) begin
            host_pending <= 1'b0;
         end

         // a tick landing while a poll is in flight stays queued, further ticks merge into it
         if (!poll_en) begin
            poll_tmr     <= TMR_RELOAD;
            poll_pending <= 1'b0;
         end else if (poll_tmr == '0) begin
            poll_tmr     <= TMR_RELOAD;
            poll_pending <= 1'b1;
         end else begin
            poll_tmr <= poll_tmr - 1'b1;
            if ((state == ISSUE) && !cur_host) poll_pending <= 1'b0;
         end

         if ((state == IDLE) && (host_pending || poll_pending)) begin
            cur_host  <= grant_host;
            last_host <= grant_host;
         end

         if (state == ISSUE)     wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 1'b1;

         if (drdy_hit) begin
            if (cur_host) begin
               if (!h_we) host_dout <= drp_dout;
            end else begin
               res_q[slot]        <= drp_dout;
               result_valid[slot] <= 1'b1;
            end
         end

         if (timed_out) begin
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
            if (cur_host) host_timeout <= 1'b1;
         end

         if ((state == DONE) && !cur_host)
            slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      end
   end

endmodule

// File: tb/tb_xadc_drp_sched.sv
// Self-checking bench for xadc_drp_sched: a behavioural XADC responder plus a
// reference register image and expected-order arithmetic for the arbiter.
module tb_xadc_drp_sched;
   localparam int NCH = 6;
   localparam int PER = 16;
   localparam int TO  = 24;

   logic                clk_usb = 1'b0;
   logic                reset_i = 1'b1;
   logic                host_req = 1'b0, host_we = 1'b0;
   logic [6:0]          host_addr = '0;
   logic [15:0]         host_din = '0;
   logic                host_busy, host_ack, host_timeout;
   logic [15:0]         host_dout;
   logic                poll_en = 1'b0;
   logic [NCH*7-1:0]    poll_addr = '0;
   logic [NCH*16-1:0]   result;
   logic [NCH-1:0]      result_valid;
   logic [7:0]          timeout_cnt;
   logic [6:0]          drp_addr;
   logic                drp_den, drp_dwe;
   logic [15:0]         drp_din;
   logic [15:0]         drp_dout = '0;
   logic                drp_drdy = 1'b0;

   xadc_drp_sched #(.pNUM_CH(NCH), .pPOLL_PERIOD(PER), .pTIMEOUT(TO)) dut (
      .clk_usb(clk_usb), .reset_i(reset_i),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
      .host_busy(host_busy), .host_ack(host_ack), .host_dout(host_dout), .host_timeout(host_timeout),
      .poll_en(poll_en), .poll_addr(poll_addr), .result(result), .result_valid(result_valid),
      .timeout_cnt(timeout_cnt), .drp_addr(drp_addr), .drp_den(drp_den), .drp_dwe(drp_dwe),
      .drp_din(drp_din), .drp_dout(drp_dout), .drp_drdy(drp_drdy));

   always #5 clk_usb = ~clk_usb;

   int checks = 0, errors = 0;
   int cyc = 0;
   always @(posedge clk_usb) cyc++;

   logic [15:0] mem [128];      // register image seen by the responder
   logic [15:0] ref_mem [128];  // what the bench expects the XADC to hold
   logic [15:0] exp_dout = '0;
   int          exp_tcnt = 0;
   int          rsp_delay = 1;  // >0 fixed drdy delay, 0 never answer, <0 random 1..6
   int          rsp_cnt = 0;
   logic [6:0]  rsp_addr = '0;
   logic        den_prev = 1'b0;
   int          den_multi = 0;
   logic [23:0] den_log[$];     // {dwe, addr, din}
   int          den_cyc[$];

   // XADC model: answers den after rsp_delay cycles, drdy high for one cycle
   always @(negedge clk_usb) begin
      if (drp_drdy) drp_drdy = 1'b0;
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            drp_drdy = 1'b1;
            drp_dout = mem[rsp_addr];
         end
      end
      if (drp_den && den_prev) den_multi++;
      den_prev = drp_den;
      if (drp_den) begin
         if (drp_dwe) mem[drp_addr] = drp_din;
         rsp_addr = drp_addr;
         rsp_cnt  = (rsp_delay < 0) ? int'($urandom_range(1, 6)) : rsp_delay;
         den_log.push_back({drp_dwe, drp_addr, drp_din});
         den_cyc.push_back(cyc);
      end
   end

   task automatic do_reset();
      reset_i = 1'b1; host_req = 1'b0; poll_en = 1'b0;
      repeat (2) @(negedge clk_usb);
      reset_i = 1'b0;
      exp_dout = '0; exp_tcnt = 0;
      @(negedge clk_usb);
   endtask

   task automatic host_txn(input logic we, input logic [6:0] a, input logic [15:0] d, input int k,
                           output logic ok, output int lat, output logic ack2);
      rsp_delay = k; den_log.delete(); den_cyc.delete();
      @(negedge clk_usb);
      host_req = 1'b1; host_we = we; host_addr = a; host_din = d;
      @(negedge clk_usb);
      host_req = 1'b0;
      ok = 1'b0; lat = -1;
      for (int i = 0; i < TO + 40; i++) begin
         if (host_ack) begin ok = 1'b1; break; end
         @(negedge clk_usb);
      end
      if (ok && den_cyc.size() > 0) lat = cyc - den_cyc[0];
      @(negedge clk_usb);
      ack2 = host_ack;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (host_busy !== 1'b0 || host_ack !== 1'b0 || host_timeout !== 1'b0) begin
         errors++; $display("FAIL reset_host: busy/ack/tmo=%b%b%b expected 000", host_busy, host_ack, host_timeout); end
      checks++; if (host_dout !== 16'h0) begin
         errors++; $display("FAIL reset_dout: got %h expected 0000", host_dout); end
      checks++; if (result !== '0 || result_valid !== '0) begin
         errors++; $display("FAIL reset_result: valid=%b expected 0", result_valid); end
      checks++; if (timeout_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_tcnt: got %0d expected 0", timeout_cnt); end
      checks++; if (drp_den !== 1'b0 || drp_dwe !== 1'b0 || drp_addr !== 7'h0 || drp_din !== 16'h0) begin
         errors++; $display("FAIL reset_drp: den=%b dwe=%b addr=%h din=%h expected zeros", drp_den, drp_dwe, drp_addr, drp_din); end
   endtask

   task automatic test_host_read();
      logic ok, ack2; int lat; logic [6:0] a; logic [15:0] d; logic we; int k;
      mem[0] = 16'hA5C3; ref_mem[0] = 16'hA5C3;
      host_txn(1'b0, 7'h00, 16'h0, 3, ok, lat, ack2);
      exp_dout = 16'hA5C3;
      checks++; if (!ok || lat != 4) begin
         errors++; $display("FAIL read_latency: ack_seen=%b latency=%0d expected 1/4", ok, lat); end
      checks++; if (host_dout !== 16'hA5C3) begin
         errors++; $display("FAIL read_dout: got %h expected a5c3", host_dout); end
      checks++; if (den_log.size() != 1 || den_log[0][23:16] !== 8'h00 || ack2 !== 1'b0) begin
         errors++; $display("FAIL read_drp: dens=%0d rec=%h ack_after=%b expected 1/00xxxx/0", den_log.size(), den_log.size() ? den_log[0] : 24'h0, ack2); end
      for (int n = 0; n < 10; n++) begin
         we = 1'($urandom_range(0, 1)); a = 7'($urandom); d = 16'($urandom); k = $urandom_range(1, 6);
         host_txn(we, a, d, k, ok, lat, ack2);
         if (we) ref_mem[a] = d; else exp_dout = ref_mem[a];
         checks++; if (!ok || lat != k + 1 || ack2 !== 1'b0) begin
            errors++; $display("FAIL rand_latency[%0d]: ack=%b lat=%0d ack_after=%b expected 1/%0d/0", n, ok, lat, ack2, k + 1); end
         checks++; if (den_log.size() != 1 || den_log[0][23:16] !== {we, a} || (we && den_log[0][15:0] !== d)) begin
            errors++; $display("FAIL rand_drp[%0d]: rec=%h expected %h", n, den_log.size() ? den_log[0] : 24'h0, {we, a, d}); end
         checks++; if (host_dout !== exp_dout) begin
            errors++; $display("FAIL rand_dout[%0d]: got %h expected %h", n, host_dout, exp_dout); end
      end
   endtask

   task automatic test_host_write();
      logic ok, ack2; int lat; int multi0;
      multi0 = den_multi;
      host_txn(1'b1, 7'h41, 16'h2000, 2, ok, lat, ack2);
      ref_mem[7'h41] = 16'h2000;
      checks++; if (!ok || den_log.size() != 1 || den_log[0] !== {1'b1, 7'h41, 16'h2000}) begin
         errors++; $display("FAIL write_drp: ack=%b rec=%h expected 1/c12000", ok, den_log.size() ? den_log[0] : 24'h0); end
      checks++; if (den_multi != multi0) begin
         errors++; $display("FAIL write_den_width: multi-cycle dens=%0d expected %0d", den_multi, multi0); end
      checks++; if (host_dout !== exp_dout) begin
         errors++; $display("FAIL write_dout: got %h expected %h", host_dout, exp_dout); end
      checks++; if (mem[7'h41] !== 16'h2000) begin
         errors++; $display("FAIL write_mem: got %h expected 2000", mem[7'h41]); end
   endtask

   task automatic test_poll();
      logic [6:0] pa [NCH]; int base, waited;
      do_reset();
      base = $urandom_range(0, 126);
      for (int i = 0; i < NCH; i++) begin
         pa[i] = 7'((base + i * 19) % 127);
         poll_addr[i*7 +: 7] = pa[i];
      end
      rsp_delay = -1; den_log.delete(); den_cyc.delete();
      poll_en = 1'b1;
      waited = 0;
      while (den_log.size() < NCH + 1 && waited < (NCH + 3) * PER) begin
         @(negedge clk_usb); waited++;
      end
      poll_en = 1'b0;
      repeat (12) @(negedge clk_usb);
      checks++; if (den_log.size() < NCH + 1) begin
         errors++; $display("FAIL poll_count: dens=%0d expected >=%0d", den_log.size(), NCH + 1); end
      for (int j = 0; j < den_log.size() && j <= NCH; j++) begin
         checks++; if (den_log[j][23:16] !== {1'b0, pa[j % NCH]}) begin
            errors++; $display("FAIL poll_order[%0d]: rec=%h expected addr %h read", j, den_log[j], pa[j % NCH]); end
         if (j > 0) begin
            checks++; if (den_cyc[j] - den_cyc[j-1] != PER) begin
               errors++; $display("FAIL poll_period[%0d]: spacing=%0d expected %0d", j, den_cyc[j] - den_cyc[j-1], PER); end
         end
      end
      checks++; if (result_valid !== '1) begin
         errors++; $display("FAIL poll_valid: got %b expected all ones", result_valid); end
      for (int i = 0; i < NCH; i++) begin
         checks++; if (result[i*16 +: 16] !== ref_mem[pa[i]]) begin
            errors++; $display("FAIL poll_result[%0d]: got %h expected %h", i, result[i*16 +: 16], ref_mem[pa[i]]); end
      end
   endtask

   task automatic test_round_robin();
      logic [6:0] pa [NCH]; int base, waited;
      do_reset();
      base = $urandom_range(0, 126);
      for (int i = 0; i < NCH; i++) begin
         pa[i] = 7'((base + i * 19) % 127);
         poll_addr[i*7 +: 7] = pa[i];
      end
      rsp_delay = 20; den_log.delete(); den_cyc.delete();
      host_we = 1'b0; host_addr = 7'h7F; host_din = '0;
      poll_en = 1'b1;
      // poll tick and host request both land on the 16th edge after enable
      repeat (15) @(negedge clk_usb);
      host_req = 1'b1;
      waited = 0;
      while (den_log.size() < 6 && waited < 400) begin
         @(negedge clk_usb); waited++;
         host_req = host_ack;
      end
      host_req = 1'b0; poll_en = 1'b0;
      repeat (60) @(negedge clk_usb);
      exp_dout = ref_mem[7'h7F];
      checks++; if (den_log.size() < 6) begin
         errors++; $display("FAIL rr_count: dens=%0d expected >=6", den_log.size()); end
      for (int j = 0; j < den_log.size() && j < 6; j++) begin
         checks++; if (den_log[j][23:16] !== {1'b0, ((j % 2) == 0) ? 7'h7F : pa[j / 2]}) begin
            errors++; $display("FAIL rr_grant[%0d]: rec=%h expected %s", j, den_log[j], ((j % 2) == 0) ? "host" : "poll"); end
      end
      checks++; if (host_dout !== exp_dout || host_busy !== 1'b0) begin
         errors++; $display("FAIL rr_end: dout=%h busy=%b expected %h/0", host_dout, host_busy, exp_dout); end
   endtask

   task automatic test_timeout();
      logic ok, ack2; int lat;
      host_txn(1'b0, 7'h10, 16'h0, 0, ok, lat, ack2);
      exp_tcnt++;
      checks++; if (!ok || lat != TO + 1 || ack2 !== 1'b0) begin
         errors++; $display("FAIL tmo_abort: ack=%b lat=%0d ack_after=%b expected 1/%0d/0", ok, lat, ack2, TO + 1); end
      checks++; if (host_timeout !== 1'b1 || timeout_cnt !== 8'(exp_tcnt)) begin
         errors++; $display("FAIL tmo_flags: host_timeout=%b cnt=%0d expected 1/%0d", host_timeout, timeout_cnt, exp_tcnt); end
      checks++; if (host_dout !== exp_dout || host_busy !== 1'b0) begin
         errors++; $display("FAIL tmo_state: dout=%h busy=%b expected %h/0", host_dout, host_busy, exp_dout); end
      host_txn(1'b0, 7'h11, 16'h0, 2, ok, lat, ack2);
      exp_dout = ref_mem[7'h11];
      checks++; if (!ok || host_timeout !== 1'b0 || host_dout !== exp_dout || timeout_cnt !== 8'(exp_tcnt)) begin
         errors++; $display("FAIL tmo_clear: ack=%b tmo=%b dout=%h cnt=%0d expected 1/0/%h/%0d", ok, host_timeout, host_dout, timeout_cnt, exp_dout, exp_tcnt); end
   endtask

   task automatic test_reset_mid();
      int waited, acks;
      checks++; if (result_valid === '0) begin
         errors++; $display("FAIL rst_pre: result_valid=%b expected nonzero from earlier polls", result_valid); end
      rsp_delay = 8; den_log.delete(); den_cyc.delete();
      @(negedge clk_usb);
      host_req = 1'b1; host_we = 1'b0; host_addr = 7'h22;
      @(negedge clk_usb);
      host_req = 1'b0;
      waited = 0;
      while (!drp_den && waited < 20) begin @(negedge clk_usb); waited++; end
      checks++; if (!drp_den) begin
         errors++; $display("FAIL rst_den: den=%b expected 1", drp_den); end
      repeat (2) @(negedge clk_usb);
      reset_i = 1'b1;
      @(negedge clk_usb);
      reset_i = 1'b0; exp_dout = '0; exp_tcnt = 0;
      checks++; if (drp_den !== 1'b0 || host_busy !== 1'b0 || result_valid !== '0 || host_ack !== 1'b0) begin
         errors++; $display("FAIL rst_mid: den=%b busy=%b valid=%b ack=%b expected 0/0/0/0", drp_den, host_busy, result_valid, host_ack); end
      acks = 0;
      repeat (15) begin @(negedge clk_usb); if (host_ack) acks++; end
      checks++; if (acks != 0 || host_dout !== exp_dout || drp_den !== 1'b0) begin
         errors++; $display("FAIL rst_after: acks=%0d dout=%h den=%b expected 0/%h/0", acks, host_dout, drp_den, exp_dout); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      test_reset();
      test_host_read();
      test_host_write();
      test_poll();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
